// File: rtl/led_share_arbiter.sv
// Round-robin owner selection for a shared LED bank.
// Registered grant/LED outputs, hold-time preemption, one blank cycle between owners.
module led_share_arbiter #(
    parameter int NO_OF_LEDS = 4,
    parameter int NO_OF_REQ  = 4,
    parameter int MAX_HOLD   = 64
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NO_OF_REQ-1:0]            req,
    input  logic [NO_OF_REQ*NO_OF_LEDS-1:0] req_pattern,
    output logic [NO_OF_REQ-1:0]            grant,
    output logic [$clog2(NO_OF_REQ)-1:0]    owner_id,
    output logic                            busy,
    output logic [NO_OF_LEDS-1:0]           led_out
);

    localparam int OWNER_W = $clog2(NO_OF_REQ);
    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam logic [OWNER_W-1:0] LAST_RST = OWNER_W'(NO_OF_REQ - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NO_OF_REQ-1:0]   r_grant;
    logic [NO_OF_REQ-1:0]   w_grant_nxt;
    logic [OWNER_W-1:0]     r_owner;
    logic [OWNER_W-1:0]     w_owner_nxt;
    logic [OWNER_W-1:0]     r_last;
    logic [OWNER_W-1:0]     w_last_nxt;
    logic [HOLD_W-1:0]      r_hold;
    logic [HOLD_W-1:0]      w_hold_nxt;
    logic [NO_OF_LEDS-1:0]  r_led;
    logic [NO_OF_LEDS-1:0]  w_led_nxt;

    logic                   w_found_hi;
    logic                   w_found_lo;
    logic [OWNER_W-1:0]     w_win_hi;
    logic [OWNER_W-1:0]     w_win_lo;
    logic                   w_found;
    logic [OWNER_W-1:0]     w_win;
    logic [NO_OF_REQ-1:0]   w_win_oh;
    logic                   w_own_req;
    logic                   w_others;
    logic [NO_OF_LEDS-1:0]  w_pat;

    // Two passes: indices above last owner first, then wrap to the low half.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = NO_OF_REQ - 1; i >= 0; i--) begin
            if (req[i] && (OWNER_W'(i) > r_last)) begin
                w_found_hi = 1'b1;
                w_win_hi   = OWNER_W'(i);
            end
            if (req[i] && (OWNER_W'(i) <= r_last)) begin
                w_found_lo = 1'b1;
                w_win_lo   = OWNER_W'(i);
            end
        end
    end

    assign w_found   = w_found_hi | w_found_lo;
    assign w_win     = w_found_hi ? w_win_hi : w_win_lo;
    assign w_win_oh  = NO_OF_REQ'(1) << w_win;
    assign w_own_req = |(req & r_grant);
    assign w_others  = |(req & ~r_grant);

    always_comb begin
        w_pat = '0;
        for (int i = 0; i < NO_OF_REQ; i++) begin
            if (r_owner == OWNER_W'(i)) begin
                w_pat = req_pattern[i*NO_OF_LEDS +: NO_OF_LEDS];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_led_nxt   = '0;
        unique case (r_state)
            S_IDLE, S_GAP: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_win_oh;
                    w_owner_nxt = w_win;
                    w_last_nxt  = w_win;
                    w_hold_nxt  = HOLD_W'(1);
                end
            end
            S_GRANT: begin
                if (!w_own_req || ((r_hold == HOLD_MAX) && w_others)) begin
                    w_state_nxt = S_GAP;
                    w_grant_nxt = '0;
                end else begin
                    w_led_nxt = w_pat;
                    if (r_hold != HOLD_MAX) begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_hold  <= '0;
            r_led   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_led   <= w_led_nxt;
        end
    end

    assign grant    = r_grant;
    assign owner_id = r_owner;
    assign busy     = (r_state == S_GRANT);
    assign led_out  = r_led;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench for led_share_arbiter: per-edge expected outputs queued
// with the stimulus, popped and compared one time unit after each rising edge.
module tb_led_share_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [15:0] req_pattern;

    logic [3:0]  g4, l4, g64, l64;
    logic [1:0]  o4, o64;
    logic        b4, b64;

    logic [10:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    led_share_arbiter #(.NO_OF_LEDS(4), .NO_OF_REQ(4), .MAX_HOLD(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .req(req), .req_pattern(req_pattern),
        .grant(g4), .owner_id(o4), .busy(b4), .led_out(l4)
    );

    led_share_arbiter #(.NO_OF_LEDS(4), .NO_OF_REQ(4), .MAX_HOLD(64)) u_dut64 (
        .clk(clk), .resetn(resetn), .req(req), .req_pattern(req_pattern),
        .grant(g64), .owner_id(o64), .busy(b64), .led_out(l64)
    );

    function automatic logic [10:0] mk(input logic [3:0] g, input logic b,
                                       input logic [3:0] l, input logic [1:0] o);
        return {g, b, l, o};
    endfunction

    task automatic apply_reset();
        resetn = 1'b0;
        req    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        resetn      = 1'b0;
        req         = '0;
        req_pattern = '0;
        #12;
        e = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        n_checks++;
        if ({g4, b4, l4, o4} !== e) begin
            n_fail++;
            $display("FAIL reset4: got %h expected %h", {g4, b4, l4, o4}, e);
        end
        n_checks++;
        if ({g64, b64, l64, o64} !== e) begin
            n_fail++;
            $display("FAIL reset64: got %h expected %h", {g64, b64, l64, o64}, e);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0]  sr[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic [3:0]  sp[5] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'h5};
        logic [10:0] ex[5];
        logic [10:0] e;
        apply_reset();
        ex[0] = mk(4'b0001, 1'b1, 4'h0, 2'd0);
        ex[1] = mk(4'b0001, 1'b1, 4'hA, 2'd0);
        ex[2] = mk(4'b0001, 1'b1, 4'h5, 2'd0);
        ex[3] = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        ex[4] = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex[i]);
            req         = sr[i];
            req_pattern = {12'h000, sp[i]};
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({g4, b4, l4, o4} !== e) begin
                n_fail++;
                $display("FAIL basic[%0d]: got %h expected %h", i, {g4, b4, l4, o4}, e);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  pats[4] = '{4'h5, 4'hA, 4'h3, 4'hC};
        logic [10:0] e;
        int          o, p;
        apply_reset();
        req_pattern = 16'hC3A5;
        req         = 4'b1111;
        for (int j = 1; j <= 21; j++) begin
            o = ((j - 1) / 5) % 4;
            p = (j - 1) % 5;
            if (p < 4)
                sb.push_back(mk(4'b0001 << o, 1'b1, (p == 0) ? 4'h0 : pats[o], 2'(o)));
            else
                sb.push_back(mk(4'b0000, 1'b0, 4'h0, 2'(o)));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({g4, b4, l4, o4} !== e) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got %h expected %h", j, {g4, b4, l4, o4}, e);
            end
        end
    endtask

    task automatic test_long_owner();
        logic [10:0] e;
        apply_reset();
        req_pattern = 16'h0709;
        req         = 4'b0100;
        for (int j = 1; j <= 203; j++) begin
            if (j == 201) req = 4'b0101;
            if (j <= 200)
                sb.push_back(mk(4'b0100, 1'b1, (j == 1) ? 4'h0 : 4'h7, 2'd2));
            else if (j == 201)
                sb.push_back(mk(4'b0000, 1'b0, 4'h0, 2'd2));
            else if (j == 202)
                sb.push_back(mk(4'b0001, 1'b1, 4'h0, 2'd0));
            else
                sb.push_back(mk(4'b0001, 1'b1, 4'h9, 2'd0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({g64, b64, l64, o64} !== e) begin
                n_fail++;
                $display("FAIL long_owner[%0d]: got %h expected %h", j, {g64, b64, l64, o64}, e);
            end
        end
    endtask

    task automatic test_lost_pulse();
        logic [3:0]  sr[6] = '{4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [10:0] ex[6];
        logic [10:0] e;
        apply_reset();
        req_pattern = 16'h0006;
        ex[0] = mk(4'b0001, 1'b1, 4'h0, 2'd0);
        ex[1] = mk(4'b0001, 1'b1, 4'h6, 2'd0);
        ex[2] = mk(4'b0001, 1'b1, 4'h6, 2'd0);
        ex[3] = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        ex[4] = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        ex[5] = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ex[i]);
            req = sr[i];
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({g4, b4, l4, o4} !== e) begin
                n_fail++;
                $display("FAIL lost_pulse[%0d]: got %h expected %h", i, {g4, b4, l4, o4}, e);
            end
        end
    endtask

    task automatic test_release_at_limit();
        logic [3:0]  sr[9] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1000,
                               4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [10:0] ex[9];
        logic [10:0] e;
        apply_reset();
        req_pattern = 16'hB00D;
        ex[0] = mk(4'b0001, 1'b1, 4'h0, 2'd0);
        ex[1] = mk(4'b0001, 1'b1, 4'hD, 2'd0);
        ex[2] = mk(4'b0001, 1'b1, 4'hD, 2'd0);
        ex[3] = mk(4'b0001, 1'b1, 4'hD, 2'd0);
        ex[4] = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        ex[5] = mk(4'b1000, 1'b1, 4'h0, 2'd3);
        ex[6] = mk(4'b1000, 1'b1, 4'hB, 2'd3);
        ex[7] = mk(4'b0000, 1'b0, 4'h0, 2'd3);
        ex[8] = mk(4'b0000, 1'b0, 4'h0, 2'd3);
        for (int i = 0; i < 9; i++) begin
            sb.push_back(ex[i]);
            req = sr[i];
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({g4, b4, l4, o4} !== e) begin
                n_fail++;
                $display("FAIL release_limit[%0d]: got %h expected %h", i, {g4, b4, l4, o4}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] e;
        apply_reset();
        req_pattern = 16'h0006;
        req         = 4'b0001;
        sb.push_back(mk(4'b0001, 1'b1, 4'h0, 2'd0));
        sb.push_back(mk(4'b0001, 1'b1, 4'h6, 2'd0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({g4, b4, l4, o4} !== e) begin
                n_fail++;
                $display("FAIL async_pre[%0d]: got %h expected %h", i, {g4, b4, l4, o4}, e);
            end
        end
        #2;
        resetn = 1'b0;
        #1;
        e = mk(4'b0000, 1'b0, 4'h0, 2'd0);
        n_checks++;
        if ({g4, b4, l4, o4} !== e) begin
            n_fail++;
            $display("FAIL async_mid: got %h expected %h", {g4, b4, l4, o4}, e);
        end
        req = 4'b1100;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        sb.push_back(mk(4'b0100, 1'b1, 4'h0, 2'd2));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({g4, b4, l4, o4} !== e) begin
            n_fail++;
            $display("FAIL async_post: got %h expected %h", {g4, b4, l4, o4}, e);
        end
        req = 4'b0000;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_long_owner();
        test_lost_pulse();
        test_release_at_limit();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_share_arbiter.md
# led_share_arbiter

Round-robin arbiter that shares one LED bank among several pattern sources, such as counter blinkers, status monitors and debug taps. Each requester holds a level request and presents its pattern. The arbiter grants one owner at a time, registers the owner's pattern onto the LEDs, and enforces a maximum hold time when others are waiting. It inserts a one-cycle blank between owners. It sits between the pattern generators and the board LED pins.

## Interface
- NO_OF_LEDS, 4, width of the LED bank and of each requester's pattern
- NO_OF_REQ, 4, number of requesters (2..16)
- MAX_HOLD, 64, grant cycles after which a waiting requester preempts the owner (≥2)
- clk  input  1  single system clock, all logic on rising edge
- resetn  input  1  asynchronous active-low reset, synchronous deassertion assumed upstream
- req  input  NO_OF_REQ  level request per requester
- req_pattern  input  NO_OF_REQ*NO_OF_LEDS  requester i pattern at bits [i*NO_OF_LEDS +: NO_OF_LEDS]
- grant  output  NO_OF_REQ  one-hot grant, registered
- owner_id  output  OWNER_W  index of current owner; OWNER_W = max(1, ceil(log2(NO_OF_REQ))); valid only while busy
- busy  output  1  high in GRANT state
- led_out  output  NO_OF_LEDS  registered LED drive

## Operation
- States: IDLE, GRANT, GAP. Reset state is IDLE.
- Reset values: grant=0, owner_id=0, busy=0, led_out=0, hold_cnt=0, last_owner=NO_OF_REQ-1. Requester 0 therefore wins the first arbitration.
- IDLE: led_out=0.
  - If any req bit is set, select the first set bit searching from last_owner+1 upward, wrapping modulo NO_OF_REQ.
  - Go to GRANT. Set grant one-hot, set owner_id and last_owner to the winner, set hold_cnt=1.
- GRANT: each cycle, led_out <= req_pattern slice of owner. The pattern is live, not latched at grant.
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Exit to GAP if req[owner]=0, or if hold_cnt==MAX_HOLD and any other req bit is set.
  - While the owner's req stays high and no one else requests, GRANT persists indefinitely with hold_cnt saturated.
- GAP: exactly one cycle, with grant=0, busy=0, led_out=0.
  - Then arbitrate as in IDLE from the new last_owner. Go to GRANT if any req is set, else IDLE.
  - The previous owner is therefore lowest priority next round.
- Requests are not latched. A req that drops before being granted is lost.
- grant stays exactly one-hot in GRANT and all-zero otherwise. owner_id holds its last value outside GRANT.

## Timing
- Request to grant: req sampled high in IDLE at edge N gives grant/busy high after edge N.
- Grant to LEDs: the first owner pattern appears on led_out one cycle after grant rises (registered sample of req_pattern during GRANT).
- Release: req[owner] sampled low at edge M gives grant=0 and led_out=0 after edge M (GAP).
  - A new grant can follow after edge M+1.
  - Minimum owner-to-owner turnaround is 2 cycles of grant low/high.
- Preemption: the owner holds grant for exactly MAX_HOLD cycles when another requester is already waiting at grant time.
- Simultaneous events:
  - Owner release and the MAX_HOLD limit on the same edge give a single GAP.
  - Several new requests in one cycle resolve by round-robin order only.
- Asynchronous reset mid-grant forces all outputs to reset values immediately, without waiting for a clock edge. The first arbitration after reset restarts at requester 0.

## Test plan
- Reset, then req=4'b0001 with pattern0=4'hA: grant=0001 one cycle later, led_out=4'hA the following cycle; drop req gives GAP, then IDLE with led_out=0.
- req=4'b1111 held constantly, MAX_HOLD=4: grants rotate 0→1→2→3→0, each owner high exactly 4 cycles, one-cycle gap between owners.
- Owner 2 alone for 200 cycles with MAX_HOLD=64: grant never drops; req[0] then rises and grant moves to 0 after the GAP.
- req[1] pulsed for one cycle while owner 0 is granted: no grant ever issued to 1 after owner 0 releases (IDLE).
- Owner release on the same edge as hold_cnt==MAX_HOLD with req[3] waiting: exactly one GAP cycle, then grant=1000.
- resetn asserted asynchronously mid-GRANT (between edges): grant, busy and led_out go to 0 before the next edge; after release, req=4'b1100 grants requester 2 first.
